// File: rtl/branch_compare_ctrl.sv
// Branch-compare sequencer: drives the shared zero/NEG comparator in true then inverted
// polarity, checks the two results are complementary, retries on mismatch, reports taken/err.
module branch_compare_ctrl #(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_s,
    input  logic             req_neg,
    output logic [31:0]      cmp_s,
    output logic             cmp_neg,
    input  logic             cmp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic             res_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault,
    input  logic             err_clr
);

    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StEvalA, StEvalB, StResp} state_e;

    state_e             state_q, state_d;
    logic [31:0]        s_q, s_d;
    logic               neg_q, neg_d;
    logic               a_q, a_d;
    logic [2:0]         retry_q, retry_d;
    logic               taken_q, taken_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic [31:0]        cmp_s_q, cmp_s_d;
    logic               cmp_neg_q, cmp_neg_d;
    logic               mismatch;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        neg_d    = neg_q;
        a_d      = a_q;
        retry_d  = retry_q;
        taken_d  = taken_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        mismatch = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    s_d     = req_s;
                    neg_d   = req_neg;
                    retry_d = 3'd0;
                    state_d = StEvalA;
                end
            end
            StEvalA: begin
                a_d     = cmp_out;
                state_d = StEvalB;
            end
            StEvalB: begin
                if (a_q != cmp_out) begin
                    taken_d = a_q;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    mismatch = 1'b1;
                    if (retry_q < MaxRetry) begin
                        retry_d = retry_q + 3'd1;
                        state_d = StEvalA;
                    end else begin
                        taken_d = 1'b0;
                        err_d   = 1'b1;
                        fault_d = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (mismatch && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        // Clear wins over a same-cycle increment or fault set.
        if (err_clr) begin
            cnt_d   = '0;
            fault_d = 1'b0;
        end

        // Comparator inputs are registered from the upcoming state so they only change on
        // state transitions.
        cmp_s_d   = 32'd0;
        cmp_neg_d = 1'b0;
        if (state_d == StEvalA) begin
            cmp_s_d   = s_d;
            cmp_neg_d = neg_d;
        end else if (state_d == StEvalB) begin
            cmp_s_d   = s_d;
            cmp_neg_d = ~neg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            s_q       <= 32'd0;
            neg_q     <= 1'b0;
            a_q       <= 1'b0;
            retry_q   <= 3'd0;
            taken_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            cmp_s_q   <= 32'd0;
            cmp_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            neg_q     <= neg_d;
            a_q       <= a_d;
            retry_q   <= retry_d;
            taken_q   <= taken_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            cmp_s_q   <= cmp_s_d;
            cmp_neg_q <= cmp_neg_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign res_valid = (state_q == StResp);
    assign res_taken = taken_q;
    assign res_err   = err_q;
    assign err_cnt   = cnt_q;
    assign fault     = fault_q;
    assign cmp_s     = cmp_s_q;
    assign cmp_neg   = cmp_neg_q;

endmodule

// File: tb/tb_branch_compare_ctrl.sv
// Bench for branch_compare_ctrl: comparator model with fault injection, directed cases
// plus randomized requests checked against a round-based reference model.
module tb_branch_compare_ctrl;

    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned CNT_W     = 8;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_s;
    logic             req_neg;
    logic [31:0]      cmp_s;
    logic             cmp_neg;
    logic             cmp_out;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic             res_err;
    logic [CNT_W-1:0] err_cnt;
    logic             fault;
    logic             err_clr;

    logic stuck = 1'b0;
    logic flip  = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_cnt   = 0;
    int m_fault = 0;

    always #5 clk = ~clk;

    // Comparator: (S==0) XOR NEG, optionally stuck at 1 or inverted for one cycle.
    assign cmp_out = stuck ? 1'b1 : (((cmp_s == 32'd0) ^ cmp_neg) ^ flip);

    branch_compare_ctrl #(
        .MAX_RETRY(MAX_RETRY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_s    (req_s),
        .req_neg  (req_neg),
        .cmp_s    (cmp_s),
        .cmp_neg  (cmp_neg),
        .cmp_out  (cmp_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_taken(res_taken),
        .res_err  (res_err),
        .err_cnt  (err_cnt),
        .fault    (fault),
        .err_clr  (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check_eq({tag, "_cmp_s"}, cmp_s, 32'd0);
        check_eq({tag, "_cmp_neg"}, 32'(cmp_neg), 32'd0);
    endtask

    // ga/gb: per-round inversion of the comparator in the A / B phase.
    task automatic run_req(input logic [31:0] s, input logic neg, input logic stk,
                           input logic [7:0] ga, input logic [7:0] gb,
                           input int stall, input int clr_cyc);
        logic a_id, ea, eb, e_taken, e_err, clr_b;
        int   rounds;
        a_id    = (s == 32'd0) ^ neg;
        rounds  = 0;
        e_taken = 1'b0;
        e_err   = 1'b0;
        for (int r = 0; r <= int'(MAX_RETRY); r++) begin
            ea     = stk ? 1'b1 : (a_id ^ ga[r]);
            eb     = stk ? 1'b1 : (~a_id ^ gb[r]);
            rounds = r + 1;
            if (clr_cyc == 2 * r) begin m_cnt = 0; m_fault = 0; end
            clr_b = (clr_cyc == 2 * r + 1);
            if (clr_b) begin m_cnt = 0; m_fault = 0; end
            if (ea != eb) begin
                e_taken = ea;
                break;
            end
            if (!clr_b) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (r == int'(MAX_RETRY)) m_fault = 1;
            end
            if (r == int'(MAX_RETRY)) e_err = 1'b1;
        end

        check_eq("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_s     = s;
        req_neg   = neg;
        stuck     = stk;
        tick();
        if (stall == 0) req_valid = 1'b0;
        res_ready = (stall == 0);
        for (int cyc = 0; cyc < 2 * rounds; cyc++) begin
            flip    = (cyc % 2 == 1) ? gb[cyc / 2] : ga[cyc / 2];
            err_clr = (cyc == clr_cyc);
            check_eq("eval_cmp_s", cmp_s, s);
            check_eq("eval_cmp_neg", 32'(cmp_neg), 32'(neg ^ (cyc % 2 == 1)));
            check_eq("eval_res_valid", 32'(res_valid), 32'd0);
            check_eq("eval_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        flip    = 1'b0;
        stuck   = 1'b0;
        err_clr = 1'b0;
        check_eq("res_valid", 32'(res_valid), 32'd1);
        check_eq("res_taken", 32'(res_taken), 32'(e_taken));
        check_eq("res_err", 32'(res_err), 32'(e_err));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
        check_eq("fault", 32'(fault), 32'(m_fault));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("stall_res_valid", 32'(res_valid), 32'd1);
            check_eq("stall_req_ready", 32'(req_ready), 32'd0);
            check_eq("stall_taken", 32'(res_taken), 32'(e_taken));
            check_eq("stall_err", 32'(res_err), 32'(e_err));
        end
        res_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_idle("post");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_s     = 32'd0;
        req_neg   = 1'b0;
        res_ready = 1'b1;
        err_clr   = 1'b0;
        #13;
        check_idle("rst");
        check_eq("rst_taken", 32'(res_taken), 32'd0);
        check_eq("rst_err", 32'(res_err), 32'd0);
        check_eq("rst_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fault-free: zero taken, nonzero not taken, inverted polarity.
        run_req(32'd0, 1'b0, 1'b0, 8'd0, 8'd0, 0, -1);
        run_req(32'h10, 1'b0, 1'b0, 8'd0, 8'd0, 0, -1);
        run_req(32'h10, 1'b1, 1'b0, 8'd0, 8'd0, 0, -1);
        // Single B-phase glitch: one retry, still good.
        run_req(32'd0, 1'b0, 1'b0, 8'd0, 8'd1, 0, -1);
        // Stuck comparator: retries exhausted.
        run_req(32'd0, 1'b0, 1'b1, 8'd0, 8'd0, 0, -1);
        // Backpressure with a request waiting.
        run_req(32'h5, 1'b1, 1'b0, 8'd0, 8'd0, 5, -1);
        // Clear coinciding with the final mismatch.
        run_req(32'd7, 1'b0, 1'b1, 8'd0, 8'd0, 0, 5);
        check_eq("clr_same_cycle_cnt", 32'(err_cnt), 32'd0);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] s;
            logic [7:0]  ga, gb;
            int          mode;
            s    = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            mode = $urandom_range(0, 9);
            ga   = 8'd0;
            gb   = 8'd0;
            if (mode >= 1 && mode <= 3) begin
                for (int b = 0; b < 8; b++) begin
                    ga[b] = ($urandom_range(0, 2) == 0);
                    gb[b] = ($urandom_range(0, 2) == 0);
                end
            end
            run_req(s, 1'($urandom_range(0, 1)), (mode == 0), ga, gb,
                    $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1);
            repeat ($urandom_range(0, 2)) begin
                check_idle("gap");
                tick();
            end
        end

        // Drive the counter into saturation.
        for (int n = 0; n < 90; n++) run_req(32'd1, 1'b0, 1'b1, 8'd0, 8'd0, 0, -1);
        check_eq("cnt_saturated", 32'(err_cnt), 32'(CNT_MAX));
        check_eq("fault_sticky", 32'(fault), 32'd1);

        // Reset during EVAL_B abandons the request.
        req_valid = 1'b1;
        req_s     = 32'd0;
        req_neg   = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("pre_rst_cmp_neg", 32'(cmp_neg), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m_cnt   = 0;
        m_fault = 0;
        check_idle("midrst");
        check_eq("midrst_cnt", 32'(err_cnt), 32'd0);
        check_eq("midrst_fault", 32'(fault), 32'd0);
        check_eq("midrst_taken", 32'(res_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_idle("after_rst");
            tick();
        end

        // Idle-time clear.
        run_req(32'd3, 1'b1, 1'b1, 8'd0, 8'd0, 0, -1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_cnt   = 0;
        m_fault = 0;
        check_eq("idle_clr_cnt", 32'(err_cnt), 32'd0);
        check_eq("idle_clr_fault", 32'(fault), 32'd0);
        run_req(32'd0, 1'b1, 1'b0, 8'd0, 8'd0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
